// File: rtl/uart_word_tx_if.sv
// rtl/uart_word_tx_if.sv - word handshake and serial-line bundle for uart_word_tx
interface uart_word_tx_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] data;
  logic                  send_en;
  logic [2:0]            baud_set;
  logic                  parity_odd;
  logic                  ready;
  logic                  uart_tx;
  logic                  tx_done;
  logic                  uart_state;

  modport master (
    output data, send_en, baud_set, parity_odd,
    input  ready, uart_tx, tx_done, uart_state
  );

  modport slave (
    input  data, send_en, baud_set, parity_odd,
    output ready, uart_tx, tx_done, uart_state
  );
endinterface

// File: rtl/uart_word_tx.sv
// rtl/uart_word_tx.sv - serialises a DATA_WIDTH word as back-to-back UART characters
// Optional parity bit per character: define UART_WORD_TX_PARITY_EN.
module uart_word_tx #(
  parameter int DATA_WIDTH = 32,
  parameter int MSB_FIRST  = 0,
  parameter int CLK_FREQ   = 50_000_000,
  parameter int STOP_BITS  = 1
) (
  input  logic          clk,
  input  logic          reset,
  uart_word_tx_if.slave bus
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int CNT_W = $clog2(CLK_FREQ / 9600 + 1);
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

`ifdef UART_WORD_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2:0]            bit_q, bit_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [2:0]            baud_q, baud_d;
  logic                  tx_q, tx_d;
  logic                  done_q, done_d;
  logic                  ready_q, ready_d;
`ifdef UART_WORD_TX_PARITY_EN
  logic                  odd_q, odd_d;
`else
  logic                  unused_parity_odd;
  assign unused_parity_odd = bus.parity_odd;
`endif

  logic [7:0]            cur_byte;
  logic [DATA_WIDTH-1:0] word_next;
  logic                  bit_end;

  function automatic logic [CNT_W-1:0] div_m1(input logic [2:0] sel);
    int unsigned baud;
    case (sel)
      3'd0:    baud = 9600;
      3'd1:    baud = 19200;
      3'd2:    baud = 38400;
      3'd3:    baud = 57600;
      3'd4:    baud = 115200;
      3'd5:    baud = 230400;
      3'd6:    baud = 460800;
      default: baud = 921600;
    endcase
    return CNT_W'(CLK_FREQ / baud - 1);
  endfunction

  // The latched word is shifted after each character so the current byte sits at a fixed end.
  always_comb begin
    if (MSB_FIRST != 0) begin
      cur_byte  = word_q[DATA_WIDTH-1 -: 8];
      word_next = word_q << 8;
    end else begin
      cur_byte  = word_q[7:0];
      word_next = word_q >> 8;
    end
  end

  assign bit_end = (cnt_q == div_m1(baud_q));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    idx_d   = idx_q;
    word_d  = word_q;
    baud_d  = baud_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    ready_d = ready_q;
`ifdef UART_WORD_TX_PARITY_EN
    odd_d   = odd_q;
`endif
    if (state_q != IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (bus.send_en && ready_q) begin
          state_d = START;
          word_d  = bus.data;
          baud_d  = bus.baud_set;
          idx_d   = '0;
          cnt_d   = '0;
          tx_d    = 1'b0;
          ready_d = 1'b0;
`ifdef UART_WORD_TX_PARITY_EN
          odd_d   = bus.parity_odd;
`endif
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = 3'd0;
          tx_d    = cur_byte[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
`ifdef UART_WORD_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = (^cur_byte) ^ odd_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
            bit_d   = 3'd0;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = cur_byte[bit_q + 3'd1];
          end
        end
      end
`ifdef UART_WORD_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
          bit_d   = 3'd0;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (bit_q != 3'(STOP_BITS - 1)) begin
            bit_d = bit_q + 3'd1;
          end else if (idx_q == IDX_W'(BYTES - 1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
            ready_d = 1'b1;
          end else begin
            // Next character starts immediately: no idle gap beyond the stop bits.
            state_d = START;
            tx_d    = 1'b0;
            idx_d   = idx_q + 1'b1;
            word_d  = word_next;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      baud_q  <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
`ifdef UART_WORD_TX_PARITY_EN
      odd_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      baud_q  <= baud_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
      ready_q <= ready_d;
`ifdef UART_WORD_TX_PARITY_EN
      odd_q   <= odd_d;
`endif
    end
  end

  assign bus.uart_tx    = tx_q;
  assign bus.ready      = ready_q;
  assign bus.tx_done    = done_q;
  assign bus.uart_state = ~ready_q;
endmodule

// File: tb/tb_uart_word_tx.sv
// tb/tb_uart_word_tx.sv - self-checking bench for uart_word_tx with a byte scoreboard
`timescale 1ns/1ps
module tb_uart_word_tx;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

`ifdef UART_WORD_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_bytes[$];
  logic       exp_par[$];

  uart_word_tx_if #(.DATA_WIDTH(32)) if0 ();
  uart_word_tx_if #(.DATA_WIDTH(32)) if1 ();
  uart_word_tx_if #(.DATA_WIDTH(8))  if2 ();
  uart_word_tx_if #(.DATA_WIDTH(8))  if3 ();

  uart_word_tx #(.DATA_WIDTH(32), .MSB_FIRST(0), .CLK_FREQ(50_000_000), .STOP_BITS(1))
    dut0 (.clk(clk), .reset(reset), .bus(if0));
  uart_word_tx #(.DATA_WIDTH(32), .MSB_FIRST(1), .CLK_FREQ(50_000_000), .STOP_BITS(1))
    dut1 (.clk(clk), .reset(reset), .bus(if1));
  uart_word_tx #(.DATA_WIDTH(8), .MSB_FIRST(0), .CLK_FREQ(50_000_000), .STOP_BITS(1))
    dut2 (.clk(clk), .reset(reset), .bus(if2));
  uart_word_tx #(.DATA_WIDTH(8), .MSB_FIRST(0), .CLK_FREQ(50_000_000), .STOP_BITS(2))
    dut3 (.clk(clk), .reset(reset), .bus(if3));

  // {uart_tx, ready, tx_done, uart_state}
  function automatic logic [3:0] probe(input int inst);
    case (inst)
      0:       return {if0.uart_tx, if0.ready, if0.tx_done, if0.uart_state};
      1:       return {if1.uart_tx, if1.ready, if1.tx_done, if1.uart_state};
      2:       return {if2.uart_tx, if2.ready, if2.tx_done, if2.uart_state};
      default: return {if3.uart_tx, if3.ready, if3.tx_done, if3.uart_state};
    endcase
  endfunction

  task automatic drive(input int inst, input logic [63:0] d, input logic [2:0] bs,
                       input logic odd, input logic en);
    case (inst)
      0: begin if0.data = d[31:0]; if0.baud_set = bs; if0.parity_odd = odd; if0.send_en = en; end
      1: begin if1.data = d[31:0]; if1.baud_set = bs; if1.parity_odd = odd; if1.send_en = en; end
      2: begin if2.data = d[7:0];  if2.baud_set = bs; if2.parity_odd = odd; if2.send_en = en; end
      default: begin if3.data = d[7:0]; if3.baud_set = bs; if3.parity_odd = odd; if3.send_en = en; end
    endcase
  endtask

  task automatic push_word(input int inst, input logic [63:0] d, input logic odd);
    int n;
    logic [7:0] b;
    n = (inst < 2) ? 4 : 1;
    for (int i = 0; i < n; i++) begin
      b = (inst == 1) ? d[(n-1-i)*8 +: 8] : d[i*8 +: 8];
      exp_bytes.push_back(b);
      exp_par.push_back((^b) ^ odd);
    end
  endtask

  // Returns with the acceptance edge just behind; the next negedge is cycle 0 of the word.
  task automatic send(input int inst, input logic [63:0] d, input logic [2:0] bs, input logic odd);
    @(negedge clk);
    drive(inst, d, bs, odd, 1'b1);
    push_word(inst, d, odd);
    @(posedge clk);
    #1 drive(inst, d, bs, odd, 1'b0);
  endtask

  task automatic rx_word(input int inst, input int div, input int tail,
                         output logic [7:0] got[$], output logic gpar[$], output int bad,
                         output int done_at, output int done_cnt, output int high_run,
                         output logic first_tx);
    int nbytes, clen, w, j, b;
    logic [7:0] cur;
    logic [3:0] s;
    nbytes = (inst < 2) ? 4 : 1;
    clen = 10 + P + ((inst == 3) ? 1 : 0);
    w = nbytes * clen * div;
    cur = 8'h00;
    got = {}; gpar = {};
    bad = 0; done_at = -1; done_cnt = 0; high_run = 0; first_tx = 1'bx;
    for (int k = 0; k < w + tail; k++) begin
      @(negedge clk);
      s = probe(inst);
      if (k == 0) first_tx = s[3];
      high_run = (s[3] === 1'b1) ? high_run + 1 : 0;
      if (s[1] === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (k < w && (k % div) == div / 2) begin
        j = k / div;
        b = j % clen;
        if (b == 0) begin
          if (s[3] !== 1'b0) bad++;
        end else if (b <= 8) begin
          cur[b-1] = s[3];
          if (b == 8) got.push_back(cur);
        end else if (P == 1 && b == 9) begin
          gpar.push_back(s[3]);
        end else if (s[3] !== 1'b1) begin
          bad++;
        end
      end
    end
  endtask

  task automatic test_reset();
    logic [3:0] s;
    reset = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 10) reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
        s = probe(i);
        checks++;
        if (s !== 4'b1100) begin
          errors++;
          $display("FAIL reset_idle inst%0d cyc%0d: got %b want 1100", i, c, s);
        end
      end
    end
  endtask

  task automatic test_lsb_first();
    logic [7:0] got[$]; logic gpar[$]; int bad, done_at, done_cnt, run; logic ftx;
    logic [7:0] e, g;
    int w;
    w = 4 * (10 + P) * 434;
    exp_bytes.delete();
    send(0, 64'h01234567, 3'd4, 1'b0);
    rx_word(0, 434, 2, got, gpar, bad, done_at, done_cnt, run, ftx);
    checks++; if (ftx !== 1'b0) begin errors++; $display("FAIL lsb_start: got %b want 0", ftx); end
    for (int i = 0; i < 4; i++) begin
      e = exp_bytes.pop_front();
      g = (got.size() > 0) ? got.pop_front() : 8'hxx;
      checks++; if (g !== e) begin errors++; $display("FAIL lsb_byte%0d: got %h want %h", i, g, e); end
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL lsb_framing: got %0d want 0", bad); end
    checks++; if (done_at !== w) begin errors++; $display("FAIL lsb_done_time: got %0d want %0d", done_at, w); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL lsb_done_width: got %0d want 1", done_cnt); end
  endtask

  task automatic test_msb_first();
    logic [7:0] got[$]; logic gpar[$]; int bad, done_at, done_cnt, run; logic ftx;
    logic [7:0] e, g;
    int w;
    w = 4 * (10 + P) * 434;
    exp_bytes.delete();
    send(1, 64'h01234567, 3'd4, 1'b0);
    rx_word(1, 434, 2, got, gpar, bad, done_at, done_cnt, run, ftx);
    for (int i = 0; i < 4; i++) begin
      e = exp_bytes.pop_front();
      g = (got.size() > 0) ? got.pop_front() : 8'hxx;
      checks++; if (g !== e) begin errors++; $display("FAIL msb_byte%0d: got %h want %h", i, g, e); end
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL msb_framing: got %0d want 0", bad); end
    checks++; if (done_at !== w) begin errors++; $display("FAIL msb_done_time: got %0d want %0d", done_at, w); end
  endtask

  task automatic test_parity();
    logic [7:0] got[$]; logic gpar[$]; int bad, done_at, done_cnt, run; logic ftx;
    logic [7:0] e, g;
    logic ep, gp;
    int w;
    w = (10 + P) * 434;
    for (int odd = 0; odd < 2; odd++) begin
      exp_bytes.delete();
      exp_par.delete();
      send(2, 64'h67, 3'd4, odd[0]);
      rx_word(2, 434, 2, got, gpar, bad, done_at, done_cnt, run, ftx);
      e = exp_bytes.pop_front();
      g = (got.size() > 0) ? got.pop_front() : 8'hxx;
      checks++; if (g !== e) begin errors++; $display("FAIL par_byte odd%0d: got %h want %h", odd, g, e); end
      checks++; if (done_at !== w) begin errors++; $display("FAIL par_char_len odd%0d: got %0d want %0d", odd, done_at, w); end
      checks++; if (bad !== 0) begin errors++; $display("FAIL par_framing odd%0d: got %0d want 0", odd, bad); end
`ifdef UART_WORD_TX_PARITY_EN
      ep = exp_par.pop_front();
      gp = (gpar.size() > 0) ? gpar.pop_front() : 1'bx;
      checks++; if (gp !== ep) begin errors++; $display("FAIL par_bit odd%0d: got %b want %b", odd, gp, ep); end
`else
      ep = 1'b0; gp = 1'b0;
`endif
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] got[$]; logic gpar[$]; int bad, done_at, done_cnt, run; logic ftx;
    logic [7:0] e, g;
    logic [3:0] s;
    int w;
    w = 4 * (10 + P) * 54;
    exp_bytes.delete();
    send(0, 64'hA5C30F96, 3'd7, 1'b0);
    fork
      rx_word(0, 54, 1, got, gpar, bad, done_at, done_cnt, run, ftx);
      begin
        repeat (300) @(negedge clk);
        s = probe(0);
        checks++; if (s[2] !== 1'b0 || s[0] !== 1'b1) begin errors++; $display("FAIL busy_flags: got %b want x0x1", s); end
        drive(0, 64'hFFFFFFFF, 3'd0, 1'b1, 1'b1);
        @(negedge clk);
        drive(0, 64'hFFFFFFFF, 3'd0, 1'b1, 1'b0);
        repeat (w + 1 - 301) @(negedge clk);
        drive(0, 64'h3C5AE718, 3'd7, 1'b0, 1'b1);
        push_word(0, 64'h3C5AE718, 1'b0);
        @(posedge clk);
        #1 drive(0, 64'h3C5AE718, 3'd7, 1'b0, 1'b0);
      end
    join
    for (int i = 0; i < 4; i++) begin
      e = exp_bytes.pop_front();
      g = (got.size() > 0) ? got.pop_front() : 8'hxx;
      checks++; if (g !== e) begin errors++; $display("FAIL b2b_w1_byte%0d: got %h want %h", i, g, e); end
    end
    checks++; if (done_at !== w) begin errors++; $display("FAIL b2b_w1_done: got %0d want %0d", done_at, w); end
    rx_word(0, 54, 2, got, gpar, bad, done_at, done_cnt, run, ftx);
    checks++; if (ftx !== 1'b0) begin errors++; $display("FAIL b2b_w2_start: got %b want 0", ftx); end
    for (int i = 0; i < 4; i++) begin
      e = exp_bytes.pop_front();
      g = (got.size() > 0) ? got.pop_front() : 8'hxx;
      checks++; if (g !== e) begin errors++; $display("FAIL b2b_w2_byte%0d: got %h want %h", i, g, e); end
    end
    checks++; if (done_at !== w) begin errors++; $display("FAIL b2b_w2_done: got %0d want %0d", done_at, w); end
  endtask

  task automatic test_stop_bits2();
    logic [7:0] got[$]; logic gpar[$]; int bad, done_at, done_cnt, run; logic ftx;
    logic [7:0] e, g;
    int w;
    w = (11 + P) * 54;
    exp_bytes.delete();
    send(3, 64'h67, 3'd7, 1'b1);
    fork
      rx_word(3, 54, 1, got, gpar, bad, done_at, done_cnt, run, ftx);
      begin
        repeat (w + 1) @(negedge clk);
        drive(3, 64'hC3, 3'd7, 1'b1, 1'b1);
        push_word(3, 64'hC3, 1'b1);
        @(posedge clk);
        #1 drive(3, 64'hC3, 3'd7, 1'b1, 1'b0);
      end
    join
    e = exp_bytes.pop_front();
    g = (got.size() > 0) ? got.pop_front() : 8'hxx;
    checks++; if (g !== e) begin errors++; $display("FAIL stop2_byte0: got %h want %h", g, e); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL stop2_framing: got %0d want 0", bad); end
    checks++; if (done_at !== w) begin errors++; $display("FAIL stop2_done: got %0d want %0d", done_at, w); end
    checks++; if (run !== 2 * 54 + 1) begin errors++; $display("FAIL stop2_gap: got %0d want %0d", run, 2 * 54 + 1); end
    rx_word(3, 54, 2, got, gpar, bad, done_at, done_cnt, run, ftx);
    checks++; if (ftx !== 1'b0) begin errors++; $display("FAIL stop2_next_start: got %b want 0", ftx); end
    e = exp_bytes.pop_front();
    g = (got.size() > 0) ? got.pop_front() : 8'hxx;
    checks++; if (g !== e) begin errors++; $display("FAIL stop2_byte1: got %h want %h", g, e); end
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] got[$]; logic gpar[$]; int bad, done_at, done_cnt, run; logic ftx;
    logic [7:0] e, g;
    logic [3:0] s;
    int w, bad_idle;
    w = 4 * (10 + P) * 54;
    send(0, 64'hDEADBEEF, 3'd7, 1'b0);
    repeat (((10 + P) + 4) * 54 + 10) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 s = probe(0);
    checks++; if (s !== 4'b1100) begin errors++; $display("FAIL abort_state: got %b want 1100", s); end
    @(negedge clk);
    reset = 1'b0;
    exp_bytes.delete();
    bad_idle = 0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      s = probe(0);
      if (s !== 4'b1100) bad_idle++;
    end
    checks++; if (bad_idle !== 0) begin errors++; $display("FAIL abort_quiet: got %0d busy cycles want 0", bad_idle); end
    send(0, 64'h13579BDF, 3'd7, 1'b0);
    rx_word(0, 54, 2, got, gpar, bad, done_at, done_cnt, run, ftx);
    for (int i = 0; i < 4; i++) begin
      e = exp_bytes.pop_front();
      g = (got.size() > 0) ? got.pop_front() : 8'hxx;
      checks++; if (g !== e) begin errors++; $display("FAIL fresh_byte%0d: got %h want %h", i, g, e); end
    end
    checks++; if (done_at !== w) begin errors++; $display("FAIL fresh_done: got %0d want %0d", done_at, w); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL fresh_done_width: got %0d want 1", done_cnt); end
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 4; i++) drive(i, 64'h0, 3'd0, 1'b0, 1'b0);
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_parity();
    test_back_to_back();
    test_stop_bits2();
    test_reset_mid_word();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_word_tx.md
# uart_word_tx

Parametrised multi-byte UART transmitter, successor to the fixed 32-bit word transmitter. It serialises one DATA_WIDTH-bit word as a back-to-back sequence of 8-bit UART characters, in selectable byte order. It adds a ready handshake, configurable stop bits, a generic clock frequency, and optional compile-time parity. It sits between a register/command source and the board's TX pin, driven from the single system clock.

## Interface

**Parameters**
- DATA_WIDTH, 32, word width; a multiple of 8 in the range 8..64; BYTES = DATA_WIDTH/8.
- MSB_FIRST, 0, byte order: 0 sends data[7:0] first; 1 sends data[DATA_WIDTH-1 -: 8] first.
- CLK_FREQ, 50_000_000, clock frequency in Hz, used for the baud divisor.
- STOP_BITS, 1, number of stop bits, 1 or 2.

**Ports**
- clk, in, 1, system clock.
- reset, in, 1, synchronous, active-high reset.
- data, in, DATA_WIDTH, word to send; sampled on acceptance.
- send_en, in, 1, request; accepted only on a clk edge where ready=1.
- baud_set, in, 3, baud select; sampled on acceptance. 0..7 = 9600, 19200, 38400, 57600, 115200, 230400, 460800, 921600.
- parity_odd, in, 1, 0 = even, 1 = odd; sampled on acceptance. Used only with UART_WORD_TX_PARITY_EN.
- ready, out, 1, high when idle and able to accept.
- uart_tx, out, 1, serial line; idles high.
- tx_done, out, 1, one-cycle pulse at the end of the word.
- uart_state, out, 1, high while a word is in flight (equals ~ready).

## Operation

- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: uart_tx=1, ready=1, uart_state=0, tx_done=0, FSM=IDLE, all counters 0.
- Divisor: DIV = CLK_FREQ / baud, integer division. Each bit lasts exactly DIV cycles; the baud counter runs 0..DIV-1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE -> START when send_en && ready. The edge of acceptance latches data, baud_set and parity_odd, and clears the byte index.
- START (uart_tx=0, one bit) -> DATA.
- DATA sends 8 bits LSB-first, then goes to PARITY if enabled, else STOP.
- PARITY sends one bit: XOR of the 8 data bits, XOR parity_odd.
- STOP sends STOP_BITS bits of 1. If more bytes remain, go to START with byte index +1; else go to IDLE and pulse tx_done.
- Bytes are sent back-to-back, with no idle gap beyond the stop bits.
- send_en while busy is ignored: no queueing, and the latched data is unaffected.
- Changing data or baud_set mid-word has no effect.
- send_en in the tx_done cycle is accepted, since ready=1 in that cycle.
- Reset mid-word aborts: uart_tx=1 on the next edge, no tx_done, FSM=IDLE.

## Timing

- Acceptance at edge k: uart_tx=0, ready=0 and uart_state=1 from after edge k.
- Character length: C = 10 + P + (STOP_BITS-1) bits, where P = 1 with parity, else 0.
- Word time: BYTES*C*DIV cycles from the acceptance edge to the end of the last stop bit.
- tx_done=1, ready=1 and uart_state=0 all hold for the single cycle immediately after the last stop bit completes. tx_done returns to 0 on the next edge.
- Back-to-back words: if send_en=1 during the tx_done cycle, the next start bit begins one cycle later. The minimum line-high time between words is therefore STOP_BITS*DIV+1 cycles.

## Configuration

- UART_WORD_TX_PARITY_EN defined: the PARITY state exists and each character carries 11 bits (plus an extra stop bit if STOP_BITS=2).
- Not defined: the PARITY state, its logic and the use of parity_odd are compiled out. The parity_odd port remains and is ignored; characters are 10 bits (11 with STOP_BITS=2).

## Test plan

1. Reset check: hold reset=1 for 10 cycles, then release. Expect uart_tx=1, ready=1, uart_state=0, tx_done=0 throughout, with no activity.
2. LSB-first word: baud_set=4, data=32'h01234567, MSB_FIRST=0, no parity, 50 MHz, 1-cycle send_en.
   - Expect bytes 67, 45, 23, 01, each bit 434 cycles.
   - Expect a tx_done pulse exactly 17360 cycles after acceptance.
3. MSB-first instance: same stimulus with MSB_FIRST=1. Expect byte order 01, 23, 45, 67.
4. Parity (macro defined), data=8'h67 with DATA_WIDTH=8:
   - parity_odd=0: parity bit = 1 (five ones).
   - parity_odd=1: parity bit = 0.
   - Expect character length 11*434 cycles.
5. Handshake:
   - Pulse send_en with data=32'hFFFFFFFF mid-word: ignored, and the output still matches the first word.
   - Assert send_en during the tx_done cycle: the next start bit follows one cycle later.
   - Check STOP_BITS=2 gives 2*DIV high cycles between characters.
6. Reset mid-word: assert reset during byte 2's DATA state. Expect uart_tx=1 on the next edge, no tx_done, ready=1. A fresh word after release transmits correctly.
